// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: RV opcodes, instruction formats,
// immediate formats and the buffered decode-field record.
package decode_stage_pkg;

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_ALUIMM = 7'b0010011;
   localparam logic [6:0] OPCODE_ALUREG = 7'b0110011;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      INST_U, INST_J, INST_I, INST_B, INST_S, INST_R, INST_UNKNOWN
   } inst_type;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
   } imm_fmt_e;

   typedef enum logic [1:0] {
      BUF_EMPTY, BUF_ONE, BUF_TWO
   } buf_state_e;

   typedef struct packed {
      inst_type   itype;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic       illegal;
   } dec_fields_t;

   localparam dec_fields_t FIELDS_RESET = '{
      itype: INST_UNKNOWN, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
      opcode: 7'd0, funct3: 3'd0, funct7: 7'd0, illegal: 1'b0
   };

   function automatic imm_fmt_e imm_fmt_of(input inst_type t);
      unique case (t)
         INST_I:  return IMM_I;
         INST_S:  return IMM_S;
         INST_B:  return IMM_B;
         INST_U:  return IMM_U;
         INST_J:  return IMM_J;
         default: return IMM_NONE;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream bundle of the decode stage; slave is the stage side,
// master is the side that feeds instructions and consumes decoded entries.
interface decode_stage_if
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [31:0]     instruction_i;
   logic [XLEN-1:0] pc_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] pc_o;
   inst_type        instruction_type_o;
   logic [4:0]      rs1_o;
   logic [4:0]      rs2_o;
   logic [4:0]      rd_o;
   logic [6:0]      opcode_o;
   logic [2:0]      funct3_o;
   logic [6:0]      funct7_o;
   logic [XLEN-1:0] imm_o;
   logic            illegal_o;

   modport slave (
      input  flush_i, valid_i, instruction_i, pc_i, ready_i,
      output ready_o, valid_o, pc_o, instruction_type_o, rs1_o, rs2_o, rd_o,
             opcode_o, funct3_o, funct7_o, imm_o, illegal_o
   );

   modport master (
      output flush_i, valid_i, instruction_i, pc_i, ready_i,
      input  ready_o, valid_o, pc_o, instruction_type_o, rs1_o, rs2_o, rd_o,
             opcode_o, funct3_o, funct7_o, imm_o, illegal_o
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction; every format sign-extends from bit 31.
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);
   logic s;
   assign s = instr_i[31];

   always_comb begin
      imm_o = '0;
      unique case (fmt_i)
         IMM_I: imm_o = {{(XLEN-12){s}}, instr_i[31:20]};
         IMM_S: imm_o = {{(XLEN-12){s}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm_o = {{(XLEN-13){s}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U: imm_o = {{(XLEN-32){s}}, instr_i[31:12], 12'b0};
         IMM_J: imm_o = {{(XLEN-21){s}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end
endmodule

// File: rtl/decode_stage.sv
// RV decode stage with a 1- or 2-entry output skid buffer.
// Optional DECODE_M_EXT_EN makes ALUREG funct7=0000001 (MUL/DIV) legal.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SKID_DEPTH = 2
) (
   input logic          clk_i,
   input logic          rst_i,
   decode_stage_if.slave bus
);
   logic [31:0]     instr;
   dec_fields_t     dec_fields;
   imm_fmt_e        dec_fmt;
   logic [XLEN-1:0] dec_imm;
   logic            funct7_ok;

   assign instr = bus.instruction_i;

`ifdef DECODE_M_EXT_EN
   assign funct7_ok = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000) ||
                      (instr[31:25] == 7'b0000001);
`else
   assign funct7_ok = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
`endif

   always_comb begin
      dec_fields        = FIELDS_RESET;
      dec_fields.opcode = instr[6:0];
      dec_fields.rd     = instr[11:7];
      dec_fields.funct3 = instr[14:12];
      dec_fields.rs1    = instr[19:15];
      dec_fields.rs2    = instr[24:20];
      dec_fields.funct7 = instr[31:25];
      case (instr[6:0])
         OPCODE_LUI, OPCODE_AUIPC:                      dec_fields.itype = INST_U;
         OPCODE_JAL:                                    dec_fields.itype = INST_J;
         OPCODE_JALR, OPCODE_LOAD, OPCODE_ALUIMM,
         OPCODE_SYSTEM:                                 dec_fields.itype = INST_I;
         OPCODE_BRANCH:                                 dec_fields.itype = INST_B;
         OPCODE_STORE:                                  dec_fields.itype = INST_S;
         OPCODE_ALUREG:                                 dec_fields.itype = INST_R;
         default:                                       dec_fields.itype = INST_UNKNOWN;
      endcase
      dec_fields.illegal = (instr[1:0] != 2'b11) || (dec_fields.itype == INST_UNKNOWN);
      if ((instr[6:0] == OPCODE_ALUREG) && !funct7_ok)
         dec_fields.illegal = 1'b1;
      // RV32 shift amounts are 5 bits; shamt[5] set has no meaning there.
      if ((XLEN == 32) && (instr[6:0] == OPCODE_ALUIMM) &&
          (instr[13:12] == 2'b01) && instr[25])
         dec_fields.illegal = 1'b1;
   end

   assign dec_fmt = imm_fmt_of(dec_fields.itype);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_i (instr),
      .fmt_i   (dec_fmt),
      .imm_o   (dec_imm)
   );

   buf_state_e      state_q, state_d;
   logic            full, valid, in_fire, out_fire;
   logic            wr_head, wr_tail, head_from_tail;
   dec_fields_t     fields_q [2];
   logic [XLEN-1:0] pc_q     [2];
   logic [XLEN-1:0] imm_q    [2];

   assign full     = (SKID_DEPTH == 1) ? (state_q == BUF_ONE) : (state_q == BUF_TWO);
   assign valid    = (state_q != BUF_EMPTY);
   assign in_fire  = bus.valid_i & ~full & ~bus.flush_i;
   assign out_fire = valid & bus.ready_i & ~bus.flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= BUF_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      wr_head        = 1'b0;
      wr_tail        = 1'b0;
      head_from_tail = 1'b0;
      if (bus.flush_i) begin
         state_d = BUF_EMPTY;
      end else begin
         unique case (state_q)
            BUF_EMPTY: if (in_fire) begin
               state_d = BUF_ONE;
               wr_head = 1'b1;
            end
            BUF_ONE: begin
               if (in_fire && out_fire) begin
                  wr_head = 1'b1;
               end else if (in_fire) begin
                  state_d = BUF_TWO;
                  wr_tail = 1'b1;
               end else if (out_fire) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_TWO: if (out_fire) begin
               state_d        = BUF_ONE;
               head_from_tail = 1'b1;
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 2; k++) begin
            fields_q[k] <= FIELDS_RESET;
            pc_q[k]     <= '0;
            imm_q[k]    <= '0;
         end
      end else begin
         if (head_from_tail) begin
            fields_q[0] <= fields_q[1];
            pc_q[0]     <= pc_q[1];
            imm_q[0]    <= imm_q[1];
         end else if (wr_head) begin
            fields_q[0] <= dec_fields;
            pc_q[0]     <= bus.pc_i;
            imm_q[0]    <= dec_imm;
         end
         if (wr_tail) begin
            fields_q[1] <= dec_fields;
            pc_q[1]     <= bus.pc_i;
            imm_q[1]    <= dec_imm;
         end
      end
   end

   assign bus.ready_o            = ~full;
   assign bus.valid_o            = valid;
   assign bus.pc_o               = pc_q[0];
   assign bus.imm_o              = imm_q[0];
   assign bus.instruction_type_o = fields_q[0].itype;
   assign bus.rs1_o              = fields_q[0].rs1;
   assign bus.rs2_o              = fields_q[0].rs2;
   assign bus.rd_o               = fields_q[0].rd;
   assign bus.opcode_o           = fields_q[0].opcode;
   assign bus.funct3_o           = fields_q[0].funct3;
   assign bus.funct7_o           = fields_q[0].funct7;
   assign bus.illegal_o          = fields_q[0].illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, handshake
// corner sequences, then random traffic against a queue-based reference.
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam logic [63:0] MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
`ifdef DECODE_M_EXT_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(XLEN)) bus ();

   decode_stage #(.XLEN(XLEN), .SKID_DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      inst_type    typ;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [63:0] imm;
      logic        ill;
      logic [63:0] pc;
   } exp_t;

   // Reference decode: immediates built by signed arithmetic on the word.
   function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
      exp_t   e;
      longint s;
      longint v;
      s     = longint'($signed(i));
      e.opc = i[6:0];
      e.rd  = i[11:7];
      e.f3  = i[14:12];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.f7  = i[31:25];
      e.pc  = pc & MASK;
      case (i[6:0])
         7'h37, 7'h17:               e.typ = INST_U;
         7'h6F:                      e.typ = INST_J;
         7'h67, 7'h03, 7'h13, 7'h73: e.typ = INST_I;
         7'h63:                      e.typ = INST_B;
         7'h23:                      e.typ = INST_S;
         7'h33:                      e.typ = INST_R;
         default:                    e.typ = INST_UNKNOWN;
      endcase
      case (e.typ)
         INST_I:  v = s >>> 20;
         INST_S:  v = (s >>> 25) * 32 + longint'(i[11:7]);
         INST_B:  v = (s >>> 31) * 4096 + longint'(i[7]) * 2048 +
                      longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
         INST_U:  v = (s >>> 12) * 4096;
         INST_J:  v = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096 +
                      longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
         default: v = 0;
      endcase
      e.imm = 64'(v) & MASK;
      e.ill = (i[1:0] != 2'b11) || (e.typ == INST_UNKNOWN);
      if (i[6:0] == 7'h33 && !(e.f7 == 7'h00 || e.f7 == 7'h20 || (M_EXT && e.f7 == 7'h01)))
         e.ill = 1'b1;
      if (XLEN == 32 && i[6:0] == 7'h13 && (e.f3 == 3'd1 || e.f3 == 3'd5) && i[25])
         e.ill = 1'b1;
      return e;
   endfunction

   task automatic chk_head(input string tag, input exp_t e);
      chk({tag, ".type"},    64'(bus.instruction_type_o), 64'(e.typ));
      chk({tag, ".rd"},      64'(bus.rd_o),      64'(e.rd));
      chk({tag, ".rs1"},     64'(bus.rs1_o),     64'(e.rs1));
      chk({tag, ".rs2"},     64'(bus.rs2_o),     64'(e.rs2));
      chk({tag, ".opcode"},  64'(bus.opcode_o),  64'(e.opc));
      chk({tag, ".funct3"},  64'(bus.funct3_o),  64'(e.f3));
      chk({tag, ".funct7"},  64'(bus.funct7_o),  64'(e.f7));
      chk({tag, ".imm"},     64'(bus.imm_o),     e.imm);
      chk({tag, ".illegal"}, 64'(bus.illegal_o), 64'(e.ill));
      chk({tag, ".pc"},      64'(bus.pc_o),      e.pc);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [10];
      logic [6:0]  f7s [4];
      logic [31:0] r;
      int          k;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
      f7s = '{7'h00, 7'h20, 7'h01, 7'h7F};
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k < 10) r[6:0] = ops[k];
      if (r[6:0] == 7'h33) r[31:25] = f7s[$urandom_range(0, 3)];
      return r;
   endfunction

   typedef struct {
      logic [31:0] instr;
      inst_type    typ;
      logic [31:0] imm;
      bit          ill;
      int          rd, rs1, rs2, f3;
   } vec_t;

   vec_t tbl [13];
   exp_t q [$];

   initial begin
      tbl[0]  = '{32'hFFF10093, INST_I,       32'hFFFFFFFF, 1'b0,    1,  2, -1,  0};
      tbl[1]  = '{32'h00112223, INST_S,       32'h00000004, 1'b0,   -1,  2,  1,  2};
      tbl[2]  = '{32'h00000000, INST_UNKNOWN, 32'h00000000, 1'b1,   -1, -1, -1, -1};
      tbl[3]  = '{32'h022081B3, INST_R,       32'h00000000, !M_EXT,  3,  1,  2,  0};
      tbl[4]  = '{32'h123452B7, INST_U,       32'h12345000, 1'b0,    5, -1, -1, -1};
      tbl[5]  = '{32'hFFDFF06F, INST_J,       32'hFFFFFFFC, 1'b0,    0, -1, -1, -1};
      tbl[6]  = '{32'h00208463, INST_B,       32'h00000008, 1'b0,   -1,  1,  2,  0};
      tbl[7]  = '{32'h02009093, INST_I,       32'h00000020, 1'b1,    1,  1, -1,  1};
      tbl[8]  = '{32'h402081B3, INST_R,       32'h00000000, 1'b0,    3,  1,  2,  0};
      tbl[9]  = '{32'h802081B3, INST_R,       32'h00000000, 1'b1,   -1, -1, -1, -1};
      tbl[10] = '{32'h00000001, INST_UNKNOWN, 32'h00000000, 1'b1,   -1, -1, -1, -1};
      tbl[11] = '{32'h00000073, INST_I,       32'h00000000, 1'b0,   -1, -1, -1, -1};
      tbl[12] = '{32'hFE112E23, INST_S,       32'hFFFFFFFC, 1'b0,   -1,  2,  1,  2};

      bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;
      bus.instruction_i = '0; bus.pc_i = '0;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.valid_o", 64'(bus.valid_o), 64'd0);
      chk("reset.ready_o", 64'(bus.ready_o), 64'd1);
      chk("reset.type",    64'(bus.instruction_type_o), 64'(INST_UNKNOWN));
      chk("reset.imm",     64'(bus.imm_o), 64'd0);
      chk("reset.pc",      64'(bus.pc_o), 64'd0);
      $display("reset released: valid_o=%0d ready_o=%0d", bus.valid_o, bus.ready_o);

      // Directed vectors, one-cycle latency each
      bus.ready_i = 1'b1;
      for (int v = 0; v < 13; v++) begin
         bus.valid_i = 1'b1;
         bus.instruction_i = tbl[v].instr;
         bus.pc_i = 32'h1000 + 32'(v) * 4;
         @(negedge clk);
         bus.valid_i = 1'b0;
         chk("vec.valid_o", 64'(bus.valid_o), 64'd1);
         chk("vec.type",    64'(bus.instruction_type_o), 64'(tbl[v].typ));
         chk("vec.imm",     64'(bus.imm_o), 64'(tbl[v].imm));
         chk("vec.illegal", 64'(bus.illegal_o), 64'(tbl[v].ill));
         chk("vec.pc",      64'(bus.pc_o), 64'(32'h1000 + 32'(v) * 4));
         if (tbl[v].rd  >= 0) chk("vec.rd",     64'(bus.rd_o),     64'(tbl[v].rd));
         if (tbl[v].rs1 >= 0) chk("vec.rs1",    64'(bus.rs1_o),    64'(tbl[v].rs1));
         if (tbl[v].rs2 >= 0) chk("vec.rs2",    64'(bus.rs2_o),    64'(tbl[v].rs2));
         if (tbl[v].f3  >= 0) chk("vec.funct3", 64'(bus.funct3_o), 64'(tbl[v].f3));
         $display("vec %0d instr=%08h type=%0d imm=%08h illegal=%0d",
                  v, tbl[v].instr, bus.instruction_type_o, bus.imm_o, bus.illegal_o);
         @(negedge clk);
      end

      // Back-pressure: third input refused, then drain in order
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1; bus.instruction_i = 32'h00100093; bus.pc_i = 32'hA0;
      @(negedge clk);
      chk("bp.ready_one", 64'(bus.ready_o), 64'd1);
      bus.instruction_i = 32'h00200113; bus.pc_i = 32'hA4;
      @(negedge clk);
      chk("bp.ready_two", 64'(bus.ready_o), 64'd0);
      chk("bp.head_a",    64'(bus.pc_o), 64'hA0);
      bus.instruction_i = 32'h00300193; bus.pc_i = 32'hA8;
      @(negedge clk);
      chk("bp.ready_hold", 64'(bus.ready_o), 64'd0);
      chk("bp.head_hold",  64'(bus.pc_o), 64'hA0);
      bus.valid_i = 1'b0; bus.ready_i = 1'b1;
      @(negedge clk);
      chk("bp.head_b",  64'(bus.pc_o), 64'hA4);
      chk("bp.b_valid", 64'(bus.valid_o), 64'd1);
      chk("bp.b_imm",   64'(bus.imm_o), 64'd2);
      @(negedge clk);
      chk("bp.drained", 64'(bus.valid_o), 64'd0);
      $display("backpressure: accepted A,B; C refused; drained in order");

      // Flush while full with a same-cycle input
      bus.ready_i = 1'b0; bus.valid_i = 1'b1;
      bus.instruction_i = 32'h00100093; bus.pc_i = 32'hB0;
      @(negedge clk);
      bus.pc_i = 32'hB4;
      @(negedge clk);
      chk("flush.pre_full", 64'(bus.ready_o), 64'd0);
      bus.flush_i = 1'b1; bus.pc_i = 32'hB8;
      @(negedge clk);
      bus.flush_i = 1'b0; bus.valid_i = 1'b0;
      chk("flush.valid_o", 64'(bus.valid_o), 64'd0);
      chk("flush.ready_o", 64'(bus.ready_o), 64'd1);
      bus.ready_i = 1'b1;
      @(negedge clk);
      chk("flush.no_ghost", 64'(bus.valid_o), 64'd0);
      $display("flush: buffer emptied, same-cycle input dropped");

      // Asynchronous reset while holding one entry
      bus.ready_i = 1'b0; bus.valid_i = 1'b1;
      bus.instruction_i = 32'hFFF10093; bus.pc_i = 32'hC0;
      @(negedge clk);
      bus.valid_i = 1'b0;
      chk("arst.pre_valid", 64'(bus.valid_o), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst.valid_o", 64'(bus.valid_o), 64'd0);
      chk("arst.type",    64'(bus.instruction_type_o), 64'(INST_UNKNOWN));
      chk("arst.imm",     64'(bus.imm_o), 64'd0);
      chk("arst.pc",      64'(bus.pc_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst.ready_o", 64'(bus.ready_o), 64'd1);
      chk("arst.idle",    64'(bus.valid_o), 64'd0);
      $display("async reset: entry discarded without a clock edge");

      // Random traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         logic in_ok, out_ok;
         @(negedge clk);
         chk("rnd.valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
         chk("rnd.ready_o", 64'(bus.ready_o), 64'(q.size() < DEPTH));
         if (q.size() != 0) chk_head("rnd", q[0]);
         bus.valid_i       = ($urandom_range(0, 3) != 0);
         bus.ready_i       = $urandom_range(0, 1);
         bus.flush_i       = ($urandom_range(0, 15) == 0);
         bus.instruction_i = rand_instr();
         bus.pc_i          = $urandom;
         in_ok  = bus.valid_i && (q.size() < DEPTH) && !bus.flush_i;
         out_ok = bus.ready_i && (q.size() != 0) && !bus.flush_i;
         @(posedge clk);
         if (bus.flush_i) begin
            q.delete();
         end else begin
            if (out_ok) begin
               $display("rnd cycle %0d: out pc=%08h type=%0d illegal=%0d",
                        c, q[0].pc, q[0].typ, q[0].ill);
               void'(q.pop_front());
            end
            if (in_ok) q.push_back(model(bus.instruction_i, 64'(bus.pc_i)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64) of imm_o and pc signals.
REQ-002 SHALL have parameter SKID_DEPTH, default 2, output buffer entries (1 or 2).
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 flush_i  input  1  discard all buffered and incoming instructions.
REQ-006 valid_i  input  1  upstream instruction valid.
REQ-007 ready_o  output  1  stage can accept an instruction.
REQ-008 instruction_i  input  32  raw instruction word.
REQ-009 pc_i  input  XLEN  PC of instruction_i.
REQ-010 valid_o  output  1  decoded entry valid.
REQ-011 ready_i  input  1  downstream accepts entry.
REQ-012 pc_o  output  XLEN  PC of entry.
REQ-013 instruction_type_o  output  inst_type  format (U/J/I/B/S/R/UNKNOWN).
REQ-014 rs1_o, rs2_o, rd_o  output  5 each  register fields.
REQ-015 opcode_o 7, funct3_o 3, funct7_o 7  output  raw fields.
REQ-016 imm_o  output  XLEN  sign-extended immediate.
REQ-017 illegal_o  output  1  entry is an illegal instruction.

Function
REQ-018 Transfer in on valid_i && ready_o; transfer out on valid_o && ready_i.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to valid_o when buffer empty.
REQ-020 Buffer FSM states EMPTY, ONE, TWO (TWO only if SKID_DEPTH=2); in-only: +1, out-only: -1, both: unchanged; FIFO order.
REQ-021 ready_o SHALL be 1 unless state is full (ONE for depth 1, TWO for depth 2); registered, no combinational path from ready_i.
REQ-022 Depth 1: simultaneous in/out while ONE not permitted (ready_o=0); no bubble required.
REQ-023 Field outputs SHALL come from the head entry; decode is performed before buffering.
REQ-024 Type map: LUI/AUIPC->U, JAL->J, JALR/LOAD/ALUIMM/SYSTEM->I, BRANCH->B, STORE->S, ALUREG->R, else UNKNOWN.
REQ-025 imm_o: I={i[31:20]}, S={i[31:25],i[11:7]}, B={i[31],i[7],i[30:25],i[11:8],0}, U={i[31:12],12'b0}, J={i[31],i[19:12],i[20],i[30:21],0}; all sign-extended from i[31] to XLEN; R/UNKNOWN=0.
REQ-026 illegal SHALL be 1 if i[1:0]!=2'b11, type UNKNOWN, or ALUREG funct7 not in {0000000, 0100000} (plus 0000001 per REQ-032).
REQ-027 ALUIMM shift (funct3 001/101) SHALL be illegal if XLEN=32 and i[25]=1.
REQ-028 Illegal entries SHALL still flow through the buffer with valid_o=1.
REQ-029 flush_i SHALL set state EMPTY next cycle and drop any same-cycle input; flush wins over all transfers.
REQ-030 Outputs other than valid_o/ready_o are don't-care when valid_o=0 but SHALL not be X.

Reset
REQ-031 On rst_i (any time, mid-transfer included): state EMPTY, valid_o=0, ready_o=1 after release, all data registers 0, instruction_type_o=INST_UNKNOWN.

Configuration
REQ-032 Macro DECODE_M_EXT_EN: defined -> ALUREG funct7 0000001 legal (MUL/DIV); undefined -> it is illegal.

Structure
REQ-033 inst_type enum, OPCODE_* constants and an imm_fmt_e enum SHALL live in the shared common constants package.
REQ-034 Immediate extraction SHALL be sub-module imm_gen (combinational, parameter XLEN).

Verification
REQ-035 addi x1,x2,-1 (0xFFF10093), XLEN=32 -> next cycle valid_o=1, INST_I, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
REQ-036 sw x1,4(x2) (0x00112223) -> INST_S, rs1=2, rs2=1, funct3=2, imm=4.
REQ-037 0x00000000 -> valid_o=1, illegal_o=1; mul x3,x1,x2 (0x022081B3) -> illegal_o=0 with DECODE_M_EXT_EN, 1 without.
REQ-038 ready_i=0, three back-to-back inputs (depth 2) -> two accepted, ready_o=0 on third; release ready_i -> outputs in order, no loss/duplicate.
REQ-039 State TWO, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, flushed input never appears.
REQ-040 rst_i asserted asynchronously while state ONE -> valid_o=0 immediately, no clock edge required.
